// File: rtl/mem_defs.sv
// rtl/mem_defs.sv - shared encodings for the MFA/MOC memory responder
package mem_defs;

    localparam logic [1:0] MEM_BYTE = 2'b00;
    localparam logic [1:0] MEM_HALF = 2'b01;
    localparam logic [1:0] MEM_WORD = 2'b10;
    localparam logic [1:0] MEM_RSVD = 2'b11;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_WAIT = 2'b01,
        S_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - access alignment, byte enables and big-endian lane mapping
module mem_lane_align
    import mem_defs::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic [1:0]        mem_type,
    input  logic [ADDR_W-1:0] addr,
    output logic [ADDR_W-1:0] aligned_addr,
    output logic [3:0]        byte_en,
    output logic [7:0]        lane_sel,
    output logic              misaligned
);

    // Byte offset i from the aligned address maps to data lane lane_sel[2i+:2];
    // the first byte in memory always lands in the most significant lane used.
    always_comb begin
        aligned_addr = addr;
        byte_en      = 4'b0001;
        lane_sel     = 8'b0000_0000;
        misaligned   = 1'b0;
        case (mem_type)
            MEM_BYTE: begin
                byte_en  = 4'b0001;
                lane_sel = 8'b0000_0000;
            end
            MEM_HALF: begin
                aligned_addr[0] = 1'b0;
                byte_en         = 4'b0011;
                lane_sel        = {2'd0, 2'd0, 2'd0, 2'd1};
                misaligned      = addr[0];
            end
            default: begin
                // Word, and the reserved code which is served as a word.
                aligned_addr[1:0] = 2'b00;
                byte_en           = 4'b1111;
                lane_sel          = {2'd0, 2'd1, 2'd2, 2'd3};
                misaligned        = (|addr[1:0]) | (mem_type == MEM_RSVD);
            end
        endcase
    end

endmodule

// File: rtl/mem_moc_responder.sv
// rtl/mem_moc_responder.sv - byte-addressable memory answering MFA with MOC
module mem_moc_responder
    import mem_defs::*;
#(
    parameter int    ADDR_W      = 8,
    parameter int    WAIT_CYCLES = 2,
    parameter string INIT_FILE   = "mem_init.txt"
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        MFA,
    input  logic        RW,
    input  logic [1:0]  TYPE,
    input  logic [31:0] ADDRESS,
    input  logic [31:0] DATA_IN,
    output logic [31:0] DATA_OUT,
    output logic        MOC,
    output logic        ALIGN_ERR
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES);

    logic [7:0] mem [DEPTH];

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  cnt;
    logic              rw_q;
    logic [1:0]        type_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       din_q;

    logic              latch_req;
    logic              do_access;
    logic              release_req;

    logic [ADDR_W-1:0] aligned_addr;
    logic [3:0]        byte_en;
    logic [7:0]        lane_sel;
    logic              misaligned;
    logic [31:0]       rd_data;
    logic [7:0]        wr_byte [4];

    // Address bits above the decoded range alias onto the array.
    wire unused_addr = &{1'b0, ADDRESS[31:ADDR_W]};

    localparam int unused_init_len = $bits(INIT_FILE);

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = 8'h00;
        end
    end

    mem_lane_align #(
        .ADDR_W(ADDR_W)
    ) u_lane_align (
        .mem_type    (type_q),
        .addr        (addr_q),
        .aligned_addr(aligned_addr),
        .byte_en     (byte_en),
        .lane_sel    (lane_sel),
        .misaligned  (misaligned)
    );

    // State register; reset aborts any request in flight.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and per-edge control strobes for the 4-phase handshake.
    always_comb begin
        state_next  = state;
        latch_req   = 1'b0;
        do_access   = 1'b0;
        release_req = 1'b0;
        case (state)
            S_IDLE: begin
                if (MFA) begin
                    state_next = S_WAIT;
                    latch_req  = 1'b1;
                end
            end
            S_WAIT: begin
                if (cnt == CNT_LAST) begin
                    state_next = S_DONE;
                    do_access  = 1'b1;
                end
            end
            S_DONE: begin
                if (!MFA) begin
                    state_next  = S_IDLE;
                    release_req = 1'b1;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Big-endian read assembly, zero-extended above the bytes accessed.
    always_comb begin
        rd_data = 32'h0;
        for (int i = 0; i < 4; i++) begin
            if (byte_en[i]) begin
                rd_data[8*lane_sel[2*i +: 2] +: 8] = mem[aligned_addr + ADDR_W'(i)];
            end
        end
    end

    // Write byte for each offset, taken from the matching lane of the latched data.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            wr_byte[i] = din_q[8*lane_sel[2*i +: 2] +: 8];
        end
    end

    // Request capture, wait counter and the registered response.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cnt       <= '0;
            rw_q      <= RW_READ;
            type_q    <= MEM_BYTE;
            addr_q    <= '0;
            din_q     <= 32'h0;
            DATA_OUT  <= 32'h0;
            MOC       <= 1'b0;
            ALIGN_ERR <= 1'b0;
        end else begin
            if (latch_req) begin
                rw_q   <= RW;
                type_q <= TYPE;
                addr_q <= ADDRESS[ADDR_W-1:0];
                din_q  <= DATA_IN;
                cnt    <= '0;
            end
            if (state == S_WAIT && !do_access) begin
                cnt <= cnt + CNT_W'(1);
            end
            if (do_access) begin
                MOC       <= 1'b1;
                ALIGN_ERR <= misaligned;
                if (rw_q == RW_READ) begin
                    DATA_OUT <= rd_data;
                end
            end
            if (release_req) begin
                MOC       <= 1'b0;
                ALIGN_ERR <= 1'b0;
            end
        end
    end

    // Array write commits only on the WAIT->DONE edge; reset never touches it.
    always_ff @(posedge CLK) begin
        if (do_access && rw_q == RW_WRITE) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) begin
                    mem[aligned_addr + ADDR_W'(i)] <= wr_byte[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_moc_responder.sv
// tb/tb_mem_moc_responder.sv - scoreboard bench for mem_moc_responder (WAIT_CYCLES 2 and 0)
module tb_mem_moc_responder;

    logic        clk = 1'b0;
    logic        rst  [2];
    logic        mfa  [2];
    logic        rw   [2];
    logic [1:0]  typ  [2];
    logic [31:0] addr [2];
    logic [31:0] din  [2];
    logic [31:0] dout [2];
    logic        moc  [2];
    logic        aerr [2];

    typedef struct {
        int          dut;
        logic [31:0] data;
        logic        err;
        int          issue;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    always #5 clk = ~clk;

    mem_moc_responder #(.ADDR_W(8), .WAIT_CYCLES(2)) dut_a (
        .CLK(clk), .RESET(rst[0]), .MFA(mfa[0]), .RW(rw[0]), .TYPE(typ[0]),
        .ADDRESS(addr[0]), .DATA_IN(din[0]), .DATA_OUT(dout[0]),
        .MOC(moc[0]), .ALIGN_ERR(aerr[0])
    );

    mem_moc_responder #(.ADDR_W(8), .WAIT_CYCLES(0)) dut_b (
        .CLK(clk), .RESET(rst[1]), .MFA(mfa[1]), .RW(rw[1]), .TYPE(typ[1]),
        .ADDRESS(addr[1]), .DATA_IN(din[1]), .DATA_OUT(dout[1]),
        .MOC(moc[1]), .ALIGN_ERR(aerr[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: checks every MOC rise against the scoreboard, then the hold/drop behaviour.
    logic        moc_p  [2];
    logic [31:0] dout_p [2];
    exp_t        e;
    always @(posedge clk) begin
        #1;
        for (int d = 0; d < 2; d++) begin
            if (rst[d]) begin
                moc_p[d] = 1'b0;
            end else begin
                if (moc[d] && !moc_p[d]) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_moc: dut %0d got MOC=1 expected no response", d);
                    end else begin
                        e = sb.pop_front();
                        chk("resp_dut", 32'(d), 32'(e.dut));
                        chk("data_out", dout[d], e.data);
                        chk("align_err", {31'b0, aerr[d]}, {31'b0, e.err});
                        chk("latency", 32'(cyc - e.issue), 32'(e.lat));
                    end
                end else if (moc_p[d]) begin
                    if (mfa[d]) begin
                        chk("moc_hold", {31'b0, moc[d]}, 32'd1);
                        chk("dout_hold", dout[d], dout_p[d]);
                    end else begin
                        chk("moc_drop", {31'b0, moc[d]}, 32'd0);
                        chk("err_drop", {31'b0, aerr[d]}, 32'd0);
                    end
                end
                moc_p[d] = moc[d];
            end
            dout_p[d] = dout[d];
        end
    end

    task automatic req(input int d, input logic r, input logic [1:0] t, input logic [31:0] a,
                       input logic [31:0] data, input logic [31:0] exp_data, input logic exp_err,
                       input int hold, input logic early_drop);
        exp_t x;
        int   n;
        @(negedge clk);
        rw[d]   = r;
        typ[d]  = t;
        addr[d] = a;
        din[d]  = data;
        mfa[d]  = 1'b1;
        x.dut   = d;
        x.data  = exp_data;
        x.err   = exp_err;
        x.issue = cyc + 1;
        x.lat   = (d == 0) ? 3 : 1;
        sb.push_back(x);
        @(negedge clk);
        addr[d] = ~a;
        din[d]  = ~data;
        if (early_drop) mfa[d] = 1'b0;
        n = 0;
        while (!moc[d] && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!moc[d]) begin
            checks++;
            errors++;
            $display("FAIL moc_timeout: dut %0d got no MOC expected MOC=1 within 20 cycles", d);
        end
        repeat (hold) @(negedge clk);
        mfa[d] = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; mfa[d] = 1'b0; rw[d] = 1'b1; typ[d] = 2'b00;
            addr[d] = 32'h0; din[d] = 32'h0;
        end
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("reset_moc", {31'b0, moc[d]}, 32'd0);
            chk("reset_err", {31'b0, aerr[d]}, 32'd0);
            chk("reset_dout", dout[d], 32'h0);
            rst[d] = 1'b0;
        end
        @(negedge clk);

        // Word write, held a few cycles, then reads of each width.
        req(0, 1'b0, 2'b10, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 3, 1'b0);
        req(0, 1'b1, 2'b00, 32'h11, 32'h0, 32'h000000AD, 1'b0, 0, 1'b0);
        req(0, 1'b1, 2'b01, 32'h12, 32'h0, 32'h0000BEEF, 1'b0, 0, 1'b0);
        req(0, 1'b1, 2'b10, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 0, 1'b0);
        // Misaligned word, aliased byte write, misaligned half with MFA dropped in WAIT.
        req(0, 1'b1, 2'b10, 32'h13, 32'h0, 32'hDEADBEEF, 1'b1, 0, 1'b0);
        req(0, 1'b0, 2'b00, 32'h110, 32'hFFFFFF55, 32'hDEADBEEF, 1'b0, 0, 1'b0);
        req(0, 1'b1, 2'b10, 32'h10, 32'h0, 32'h55ADBEEF, 1'b0, 0, 1'b0);
        req(0, 1'b1, 2'b01, 32'h11, 32'h0, 32'h000055AD, 1'b1, 1, 1'b1);

        // Write aborted by reset during WAIT: no response, nothing committed.
        @(negedge clk);
        rw[0] = 1'b0; typ[0] = 2'b10; addr[0] = 32'h20; din[0] = 32'h12345678; mfa[0] = 1'b1;
        @(negedge clk);
        rst[0] = 1'b1;
        mfa[0] = 1'b0;
        #1;
        chk("abort_moc", {31'b0, moc[0]}, 32'd0);
        @(negedge clk);
        rst[0] = 1'b0;
        chk("abort_dout", dout[0], 32'h0);
        repeat (5) @(negedge clk);
        chk("abort_moc_idle", {31'b0, moc[0]}, 32'd0);
        req(0, 1'b1, 2'b10, 32'h20, 32'h0, 32'h00000000, 1'b0, 0, 1'b0);
        req(0, 1'b0, 2'b01, 32'h22, 32'hAAAA1234, 32'h00000000, 1'b0, 0, 1'b0);
        req(0, 1'b1, 2'b10, 32'h20, 32'h0, 32'h00001234, 1'b0, 0, 1'b0);
        req(0, 1'b1, 2'b00, 32'h123, 32'h0, 32'h00000034, 1'b0, 0, 1'b0);

        // MFA held long after DONE, then a one-edge gap and a second request.
        req(0, 1'b1, 2'b10, 32'h10, 32'h0, 32'h55ADBEEF, 1'b0, 10, 1'b0);
        req(0, 1'b1, 2'b10, 32'h10, 32'h0, 32'h55ADBEEF, 1'b0, 0, 1'b0);

        // Zero-wait instance: latency 1 and the reserved type served as a word.
        req(1, 1'b0, 2'b10, 32'h10, 32'hCAFEF00D, 32'h0, 1'b0, 0, 1'b0);
        req(1, 1'b1, 2'b11, 32'h10, 32'h0, 32'hCAFEF00D, 1'b1, 0, 1'b0);
        req(1, 1'b1, 2'b11, 32'h12, 32'h0, 32'hCAFEF00D, 1'b1, 2, 1'b0);
        req(1, 1'b1, 2'b00, 32'h13, 32'h0, 32'h0000000D, 1'b0, 0, 1'b0);

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
